// File: rtl/ena_burst_gen.sv
// Enable-line burst train generator: high bursts shrinking by one cycle from
// start_len down to min_len, separated by programmable low gaps.
module ena_burst_gen #(
  parameter int LEN_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] start_len,
  input  logic [LEN_W-1:0] min_len,
  input  logic [GAP_W-1:0] gap_len,
  output logic             ena,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] cur_len,
  output logic [LEN_W-1:0] burst_cnt
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] min_q, hcnt_q, len_q, bcnt_q;
  logic [GAP_W-1:0] gap_q, gcnt_q;
  logic             ena_q, busy_q, done_q;
  logic             ena_d, busy_d, done_d;

  logic [LEN_W-1:0] eff_min;
  logic [GAP_W-1:0] eff_gap;
  logic             take, len_ok, high_last, gap_last, at_min;

  always_comb begin
    eff_min   = (min_len == '0) ? LEN_W'(1) : min_len;
    eff_gap   = (gap_len == '0) ? GAP_W'(1) : gap_len;
    take      = start && !abort;
    len_ok    = (start_len >= eff_min);
    high_last = (hcnt_q == LEN_W'(1));
    gap_last  = (gcnt_q == GAP_W'(1));
    at_min    = (len_q == min_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (take) state_d = len_ok ? HIGH : FIN;
      HIGH: begin
        if (abort)          state_d = IDLE;
        else if (high_last) state_d = at_min ? FIN : LOW;
      end
      LOW: begin
        if (abort)         state_d = IDLE;
        else if (gap_last) state_d = HIGH;
      end
      FIN: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so they trail the state by
  // one cycle; abort is folded in so the line drops on the edge that sees it.
  always_comb begin
    ena_d  = (state_q == HIGH) && !abort;
    busy_d = (state_q == FIN) || (((state_q == HIGH) || (state_q == LOW)) && !abort);
    done_d = (state_q == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ena_q  <= ena_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q  <= '0;
      gap_q  <= '0;
      len_q  <= '0;
      bcnt_q <= '0;
      hcnt_q <= '0;
      gcnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (take) begin
          min_q <= eff_min;
          gap_q <= eff_gap;
          if (len_ok) begin
            len_q  <= start_len;
            hcnt_q <= start_len;
            bcnt_q <= LEN_W'(1);
          end else begin
            len_q  <= '0;
            bcnt_q <= '0;
          end
        end
        HIGH: if (!abort) begin
          if (high_last) gcnt_q <= gap_q;
          else           hcnt_q <= hcnt_q - LEN_W'(1);
        end
        LOW: if (!abort) begin
          if (gap_last) begin
            len_q  <= len_q - LEN_W'(1);
            hcnt_q <= len_q - LEN_W'(1);
            bcnt_q <= bcnt_q + LEN_W'(1);
          end else begin
            gcnt_q <= gcnt_q - GAP_W'(1);
          end
        end
        FIN: ;
      endcase
    end
  end

  assign ena       = ena_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cur_len   = len_q;
  assign burst_cnt = bcnt_q;

endmodule

// File: tb/tb_ena_burst_gen.sv
// Bench for ena_burst_gen: per-cycle expected {ena,busy,done} pushed at start,
// popped and compared every cycle; end-of-train counters checked separately.
module tb_ena_burst_gen;

  localparam int LEN_W = 4;
  localparam int GAP_W = 3;

  typedef struct packed {
    logic ena;
    logic busy;
    logic done;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [LEN_W-1:0] start_len, min_len;
  logic [GAP_W-1:0] gap_len;
  logic             ena, busy, done;
  logic [LEN_W-1:0] cur_len, burst_cnt;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  ena_burst_gen #(.LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .start_len(start_len), .min_len(min_len), .gap_len(gap_len),
    .ena(ena), .busy(busy), .done(done),
    .cur_len(cur_len), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Drives one train and compares it cycle by cycle. Entry i of the scoreboard
  // is the output state after edge k+i, where k is the edge sampling start.
  task automatic run_train(input logic [LEN_W-1:0] sl, input logic [LEN_W-1:0] ml,
                           input logic [GAP_W-1:0] gl, input int abort_at,
                           input int extra_start_at, input int rst_at);
    exp_t full[$];
    int   em, eg, i;
    exp_t e;
    em = (ml == 0) ? 1 : int'(ml);
    eg = (gl == 0) ? 1 : int'(gl);
    full.push_back('{1'b0, 1'b0, 1'b0});
    if (int'(sl) >= em) begin
      for (int l = int'(sl); l >= em; l--) begin
        for (int c = 0; c < l; c++) full.push_back('{1'b1, 1'b1, 1'b0});
        if (l != em) for (int c = 0; c < eg; c++) full.push_back('{1'b0, 1'b1, 1'b0});
      end
    end
    full.push_back('{1'b0, 1'b1, 1'b1});
    full.push_back('{1'b0, 1'b0, 1'b0});
    full.push_back('{1'b0, 1'b0, 1'b0});

    @(negedge clk);
    start = 1'b1; start_len = sl; min_len = ml; gap_len = gl;
    for (int j = 0; j < full.size(); j++)
      sb.push_back((abort_at != 0 && j >= abort_at) ? exp_t'('0) : full[j]);

    i = 0;
    while (sb.size() > 0 && i < 400) begin
      @(negedge clk);
      start = (extra_start_at != 0 && i == extra_start_at);
      abort = (abort_at != 0 && i == abort_at - 1);
      start_len = LEN_W'($urandom);
      min_len   = LEN_W'($urandom);
      gap_len   = GAP_W'($urandom);
      e = sb.pop_front();
      check("ena", ena, e.ena);
      check("busy", busy, e.busy);
      check("done", done, e.done);
      if (rst_at != 0 && i == rst_at) begin
        #2 rst = 1'b1;
        #1;
        check("rst_ena", ena, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_len", cur_len, 0);
        check("rst_burst_cnt", burst_cnt, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
      end
      i++;
    end
    check("sb_drained", sb.size(), 0);
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    start_len = '0; min_len = '0; gap_len = '0;
    #1;
    check("reset_ena", ena, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_cur_len", cur_len, 0);
    check("reset_burst_cnt", burst_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_train(4'd8, 4'd1, 3'd1, 0, 0, 0);
    check("t1_burst_cnt", burst_cnt, 8);
    check("t1_cur_len", cur_len, 1);

    run_train(4'd5, 4'd3, 3'd3, 0, 0, 0);
    check("t2_burst_cnt", burst_cnt, 3);
    check("t2_cur_len", cur_len, 3);

    run_train(4'd2, 4'd4, 3'd2, 0, 0, 0);
    check("t3_burst_cnt", burst_cnt, 0);

    run_train(4'd0, 4'd1, 3'd1, 0, 0, 0);
    check("t4_burst_cnt", burst_cnt, 0);

    run_train(4'd3, 4'd0, 3'd0, 0, 0, 0);
    check("t5_burst_cnt", burst_cnt, 3);
    check("t5_cur_len", cur_len, 1);

    // abort sampled at edge k+9, one cycle into the 4-cycle second burst
    run_train(4'd5, 4'd1, 3'd2, 9, 2, 0);
    check("t6_burst_cnt", burst_cnt, 2);
    check("t6_cur_len", cur_len, 4);

    run_train(4'd6, 4'd1, 3'd1, 0, 0, 3);

    run_train(4'd4, 4'd2, 3'd1, 0, 0, 0);
    check("t8_burst_cnt", burst_cnt, 3);
    check("t8_cur_len", cur_len, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
